// File: rtl/stripes_transposer_stream_if.sv
// stripes_transposer_stream_if: brick-in / bit-plane-out handshake bundle
interface stripes_transposer_stream_if #(
    parameter int WL       = 16,
    parameter int WORDS    = 16,
    parameter int SEL_BITS = 4
);
    logic                   i_valid;
    logic                   o_ready;
    logic [WL*WORDS-1:0]    i_data;
    logic [SEL_BITS:0]      i_prec;
    logic                   o_valid;
    logic                   i_ready;
    logic [WORDS-1:0]       o_stream;
    logic [SEL_BITS-1:0]    o_bit_idx;
    logic                   o_last;

    modport slave (
        input  i_valid, i_data, i_prec, i_ready,
        output o_ready, o_valid, o_stream, o_bit_idx, o_last
    );

    modport master (
        output i_valid, i_data, i_prec, i_ready,
        input  o_ready, o_valid, o_stream, o_bit_idx, o_last
    );
endinterface

// File: rtl/stripes_transposer_stream.sv
// stripes_transposer_stream: double-buffered brick to bit-plane serialiser
module stripes_transposer_stream #(
    parameter int WL        = 16,
    parameter int WORDS     = 16,
    parameter int SEL_BITS  = 4,
    parameter bit MSB_FIRST = 0
) (
    input logic clk,
    input logic rst,
    stripes_transposer_stream_if.slave stream_io
);
    localparam int PW = SEL_BITS + 1;
    localparam logic [PW-1:0] WLP = PW'(WL);

    logic [WL*WORDS-1:0] h_q, h_d, s_q, s_d;
    logic [PW-1:0]       hp_q, hp_d, sp_q, sp_d;
    logic [SEL_BITS-1:0] cnt_q, cnt_d;
    logic                h_full_q, h_full_d, s_busy_q, s_busy_d;
    logic                accept, adv, last, xfer;
    logic [PW-1:0]       clamp, pm1;
    logic [SEL_BITS-1:0] idx;

    assign stream_io.o_ready = !h_full_q && !rst;
    assign accept = stream_io.i_valid && stream_io.o_ready;
    assign adv    = s_busy_q && stream_io.i_ready;
    assign pm1    = sp_q - 1'b1;
    assign last   = s_busy_q && ({1'b0, cnt_q} == pm1);
    assign xfer   = h_full_q && (!s_busy_q || (adv && last));
    assign clamp  = (stream_io.i_prec == '0 || stream_io.i_prec > WLP) ? WLP : stream_io.i_prec;
    assign idx    = MSB_FIRST ? SEL_BITS'(pm1 - {1'b0, cnt_q}) : cnt_q;

    assign stream_io.o_valid   = s_busy_q;
    assign stream_io.o_last    = last;
    assign stream_io.o_bit_idx = s_busy_q ? idx : '0;

    for (genvar j = 0; j < WORDS; j++) begin : g_plane
        logic [WL-1:0] w;
        assign w = s_q[j*WL +: WL];
        assign stream_io.o_stream[j] = s_busy_q && w[idx];
    end

    // next state: a transfer refills S and overrides both the count step and the end-of-brick clear
    always_comb begin
        h_d      = accept ? stream_io.i_data : h_q;
        hp_d     = accept ? clamp : hp_q;
        h_full_d = xfer ? 1'b0 : (accept ? 1'b1 : h_full_q);
        s_d      = xfer ? h_q : s_q;
        sp_d     = xfer ? hp_q : sp_q;
        cnt_d    = (xfer || (adv && last)) ? '0 : (adv ? cnt_q + 1'b1 : cnt_q);
        s_busy_d = xfer ? 1'b1 : ((adv && last) ? 1'b0 : s_busy_q);
    end

    // control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            h_full_q <= 1'b0;
            s_busy_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            h_full_q <= h_full_d;
            s_busy_q <= s_busy_d;
            cnt_q    <= cnt_d;
        end
    end

    // bank data and precisions need no reset; they are qualified by h_full/s_busy
    always_ff @(posedge clk) begin
        h_q  <= h_d;
        hp_q <= hp_d;
        s_q  <= s_d;
        sp_q <= sp_d;
    end
endmodule
